// File: rtl/kpemu_pkg.sv
`timescale 1ns/1ps
// Shared types, line patterns and key-to-(row,col) lookup for keypad_emulator.
// ST_BOUNCE is only ever entered when KPEMU_BOUNCE_EN is defined.
package kpemu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_BOUNCE  = 2'd3
  } state_t;

  localparam logic [3:0] IDLE_COL = 4'b1111;

  // Index 0..3 -> active-low one-hot line pattern, shared by rows and columns.
  localparam logic [3:0] LINE_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t p;
    case (key)
      4'h1:    p = '{2'd0, 2'd0};
      4'h2:    p = '{2'd0, 2'd1};
      4'h3:    p = '{2'd0, 2'd2};
      4'hA:    p = '{2'd0, 2'd3};
      4'h4:    p = '{2'd1, 2'd0};
      4'h5:    p = '{2'd1, 2'd1};
      4'h6:    p = '{2'd1, 2'd2};
      4'hB:    p = '{2'd1, 2'd3};
      4'h7:    p = '{2'd2, 2'd0};
      4'h8:    p = '{2'd2, 2'd1};
      4'h9:    p = '{2'd2, 2'd2};
      4'hC:    p = '{2'd2, 2'd3};
      4'hE:    p = '{2'd3, 2'd0};
      4'h0:    p = '{2'd3, 2'd1};
      4'hF:    p = '{2'd3, 2'd2};
      default: p = '{2'd3, 2'd3};  // 4'hD
    endcase
    return p;
  endfunction

endpackage

// File: rtl/kpemu_keymap.sv
`timescale 1ns/1ps
// Combinational key code -> target row strobe pattern and column drive pattern.
module kpemu_keymap
  import kpemu_pkg::*;
(
  input  logic [3:0] key,
  output logic [3:0] row_pat,
  output logic [3:0] col_pat
);

  key_pos_t pos;

  always_comb begin
    pos     = key_to_pos(key);
    row_pat = LINE_PAT[pos.row];
    col_pat = LINE_PAT[pos.col];
  end

endmodule

// File: rtl/keypad_emulator.sv
`timescale 1ns/1ps
// Matrix-keypad responder: presses one key for HOLD_SCANS target-row visits, then releases it.
// Define KPEMU_BOUNCE_EN to precede the hold with BOUNCE_VISITS alternating bounce visits.
module keypad_emulator
  import kpemu_pkg::*;
#(
  parameter int HOLD_SCANS    = 16,
  parameter int RELEASE_SCANS = 16,
  parameter int BOUNCE_VISITS = 3,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rowwrite,
  output logic [3:0] colread,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic logic [CNT_W-1:0] sat_limit(input int n, input int floor_v);
    int v;
    v = (n < floor_v) ? floor_v : n;
    if (v > CNT_MAX) v = CNT_MAX;
    return v[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  localparam logic [CNT_W-1:0] HOLD_LIM = sat_limit(HOLD_SCANS, 1);
  localparam logic [CNT_W-1:0] REL_LIM  = sat_limit(RELEASE_SCANS, 1);
  localparam logic [CNT_W-1:0] BNC_LIM  = sat_limit(BOUNCE_VISITS, 0);

`ifdef KPEMU_BOUNCE_EN
  localparam bit BOUNCE_ON = (BNC_LIM != '0);
`else
  localparam bit BOUNCE_ON = 1'b0 && (BNC_LIM != '0);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       row_q;
  logic [3:0]       tgt_row;
  logic [3:0]       tgt_col;
  logic [3:0]       key_row;
  logic [3:0]       key_col;
  logic             on_row;
  logic             visit;
  logic             accept;

  kpemu_keymap u_keymap (
    .key     (key_in),
    .row_pat (key_row),
    .col_pat (key_col)
  );

  // tgt_row is always one-hot-low, so idle or malformed strobes never match.
  assign on_row = (rowwrite == tgt_row);
  assign visit  = on_row && (rowwrite != row_q);
  assign accept = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_row <= key_row;
      tgt_col <= key_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      row_q     <= IDLE_COL;
      colread   <= IDLE_COL;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      row_q   <= rowwrite;
      colread <= IDLE_COL;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= BOUNCE_ON ? ST_BOUNCE : ST_PRESS;
            cnt       <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
`ifdef KPEMU_BOUNCE_EN
        ST_BOUNCE: begin
          // Odd-numbered bounce visits are pressed; leave once the last one is over.
          if (cnt == BNC_LIM && !on_row) begin
            state <= ST_PRESS;
            cnt   <= '0;
          end else if (visit) begin
            cnt <= inc_sat(cnt);
            if (!cnt[0]) colread <= tgt_col;
          end else if (on_row && cnt[0]) begin
            colread <= tgt_col;
          end
        end
`endif
        ST_PRESS: begin
          if (visit && cnt == HOLD_LIM) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end else begin
            if (on_row) colread <= tgt_col;
            if (visit)  cnt     <= inc_sat(cnt);
          end
        end
        ST_RELEASE: begin
          if (visit) begin
            if (cnt == REL_LIM) begin
              state     <= ST_IDLE;
              cnt       <= '0;
              done      <= 1'b1;
              key_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt <= inc_sat(cnt);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
